hazard_fwd_ctrl: RTL
====================

# hazard_fwd_ctrl

Parametrised hazard, forwarding and flush controller; the next-generation replacement for the decode-stage hazard logic. It sits beside the ID stage, tracks in-flight writers through a configurable number of downstream stages, and produces registered one-hot bypass selects, load-use stalls and flow-change flushes. It also latches halt and signals it at writeback. It generalises source-port count, register-file size, forwarding depth, load latency and flush depth.

## Interface
- NUM_SRC, 2: register read ports per instruction
- REG_AW, 4: register address width; address 0 is hard-wired zero and never bypassed or hazarded
- FWD_STAGES, 2: tracked stages after ID; stage 0 = ID_EX, stage FWD_STAGES-1 = last stage before writeback; range 1..8
- LOAD_LAT, 1: a load in tracker stage k < LOAD_LAT cannot forward; range 0..FWD_STAGES
- FLUSH_DEPTH, 2: cycles `flush` stays high per flow change, counting the flow_change cycle; range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_re  in  NUM_SRC  per-port read enable
- id_src_addr  in  NUM_SRC*REG_AW  port s at [s*REG_AW +: REG_AW]
- id_we  in  1  instruction writes RF
- id_dst_addr  in  REG_AW  destination register
- id_is_load  in  1  instruction is a load
- id_hlt  in  1  instruction is HLT
- flow_change  in  1  taken branch/jump resolved in EX this cycle
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_id_ex  out  1  ID instruction is not issued; ID_EX gets a NOP
- byp_oh  out  NUM_SRC*FWD_STAGES  registered; port s at [s*FWD_STAGES +: FWD_STAGES]
- flush  out  1  kill younger instructions
- halted  out  1  sticky halt
- hlt_wb  out  1  sticky; HLT reached writeback

## Operation
- Tracker: FWD_STAGES entries {we, dst, ld, hlt}. It shifts every cycle: entry k+1 <= entry k. Entry 0 <= ID instruction if issued, else all-zero.
- Issue: issue = id_valid & !hazard & !flush & !halted; bubble_id_ex = !issue.
- Match for port s at stage k: id_re[s] & (addr_s != 0) & entry[k].we & (entry[k].dst == addr_s). The youngest match (lowest k) wins.
- hazard: any port whose winning match has entry[k].ld and k < LOAD_LAT.
- stall_if_id = (hazard & !flush) | halted.
- byp_oh[s][k] is registered every cycle. It is one-hot for the winning match, or 0 if there is no match, a hazard, or a flush. In the cycle after capture, bit k selects the result held in pipeline stage k+1 (the last stage selects the writeback value).
- Flush counter: flow_change loads FLUSH_DEPTH-1. The counter decrements to 0. flush = flow_change | (cnt != 0). A flow_change during an active window reloads the counter.
- Halt: issue & id_hlt sets `halted`, which stays set until rst. The hlt bit travels the tracker. hlt_wb is set the cycle after it leaves entry FWD_STAGES-1 and stays set.
- Priority: rst > flush > hazard. flush together with hazard gives stall_if_id=0, bubble=1. flush together with id_hlt means halt is not taken.

## Timing
- Reset: all tracker entries 0, cnt=0. halted, hlt_wb, byp_oh = 0. Therefore stall_if_id=0, flush=flow_change, bubble_id_ex=!id_valid|flow_change.
- rst mid-operation clears everything on the next edge, including an active flush window and halted.
- Load-use penalty = LOAD_LAT - k stall cycles. With defaults, the penalty is 1 cycle for back-to-back use.
- byp_oh latency: 1 cycle. Hazard, stall, flush and bubble are combinational from state and inputs, with no input-to-output register.
- HLT issued at cycle t gives halted=1 at t+1 and hlt_wb=1 at t+FWD_STAGES+1.

## Test plan
- Defaults. Issue ADD R3; next cycle ADD reads R3 on port 1 -> byp_oh[1*2+0]=1 one cycle later; no stall.
- LW R5, then immediate use of R5 on port 0 -> stall_if_id=1 and bubble=1 for exactly 1 cycle; next cycle byp_oh[1]=1 (stage-1 forward).
- LOAD_LAT=2, FWD_STAGES=3: load then dependent use -> 2 stall cycles, then forward from stage 2.
- flow_change at cycle 10, again at cycle 11 -> flush high cycles 10-12, bubble high throughout, nothing enters tracker.
- flow_change same cycle as a load-use hazard -> stall_if_id=0, bubble=1, byp_oh=0 next cycle.
- HLT issued at t with defaults -> halted at t+1, stall_if_id held 1, hlt_wb at t+3; rst then clears all outputs to 0.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Decode-stage hazard, forwarding and flush controller. It tracks in-flight writers
// through FWD_STAGES downstream stages and produces bypass selects, stalls, flushes and halt status.
module hazard_fwd_ctrl #(
  parameter int NUM_SRC     = 2,
  parameter int REG_AW      = 4,
  parameter int FWD_STAGES  = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NUM_SRC-1:0]             id_re,
  input  logic [NUM_SRC*REG_AW-1:0]      id_src_addr,
  input  logic                           id_we,
  input  logic [REG_AW-1:0]              id_dst_addr,
  input  logic                           id_is_load,
  input  logic                           id_hlt,
  input  logic                           flow_change,
  output logic                           stall_if_id,
  output logic                           bubble_id_ex,
  output logic [NUM_SRC*FWD_STAGES-1:0]  byp_oh,
  output logic                           flush,
  output logic                           halted,
  output logic                           hlt_wb
);

  localparam int CW = 4;
  localparam int BW = NUM_SRC * FWD_STAGES;

  logic              trk_we_r  [FWD_STAGES];
  logic [REG_AW-1:0] trk_dst_r [FWD_STAGES];
  logic              trk_ld_r  [FWD_STAGES];
  logic              trk_hlt_r [FWD_STAGES];
  logic [CW-1:0]     cnt_r;
  logic              halted_r;
  logic              hlt_wb_r;
  logic [BW-1:0]     byp_oh_r;

  logic              hazard_s;
  logic              flush_s;
  logic              issue_s;
  logic [NUM_SRC-1:0] found_s;
  logic [BW-1:0]     byp_hit_s;
  logic [BW-1:0]     byp_nxt_s;

  // Youngest-match search per read port; a load still inside its latency window raises hazard.
  always_comb begin
    hazard_s  = 1'b0;
    found_s   = {NUM_SRC{1'b0}};
    byp_hit_s = {BW{1'b0}};
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        logic match_v;
        logic hit_v;
        match_v = id_re[s] & (id_src_addr[s*REG_AW +: REG_AW] != {REG_AW{1'b0}}) &
                  trk_we_r[k] & (trk_dst_r[k] == id_src_addr[s*REG_AW +: REG_AW]);
        hit_v   = match_v & ~found_s[s];
        found_s[s] = found_s[s] | match_v;
        byp_hit_s[s*FWD_STAGES + k] = hit_v;
        hazard_s = hazard_s | (hit_v & trk_ld_r[k] & (k < LOAD_LAT));
      end
    end
    flush_s   = flow_change | (cnt_r != {CW{1'b0}});
    issue_s   = id_valid & ~hazard_s & ~flush_s & ~halted_r;
    byp_nxt_s = (hazard_s | flush_s) ? {BW{1'b0}} : byp_hit_s;
  end

  assign stall_if_id  = (hazard_s & ~flush_s) | halted_r;
  assign bubble_id_ex = ~issue_s;
  assign flush        = flush_s;
  assign byp_oh       = byp_oh_r;
  assign halted       = halted_r;
  assign hlt_wb       = hlt_wb_r;

  // Tracker shift, flush window counter, sticky halt flags and registered bypass selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        trk_we_r[k]  <= 1'b0;
        trk_dst_r[k] <= {REG_AW{1'b0}};
        trk_ld_r[k]  <= 1'b0;
        trk_hlt_r[k] <= 1'b0;
      end
      cnt_r    <= {CW{1'b0}};
      halted_r <= 1'b0;
      hlt_wb_r <= 1'b0;
      byp_oh_r <= {BW{1'b0}};
    end else begin
      for (int k = FWD_STAGES - 1; k > 0; k--) begin
        trk_we_r[k]  <= trk_we_r[k-1];
        trk_dst_r[k] <= trk_dst_r[k-1];
        trk_ld_r[k]  <= trk_ld_r[k-1];
        trk_hlt_r[k] <= trk_hlt_r[k-1];
      end
      trk_we_r[0]  <= issue_s & id_we;
      trk_dst_r[0] <= issue_s ? id_dst_addr : {REG_AW{1'b0}};
      trk_ld_r[0]  <= issue_s & id_is_load;
      trk_hlt_r[0] <= issue_s & id_hlt;
      if (flow_change) begin
        cnt_r <= CW'(FLUSH_DEPTH - 1);
      end else if (cnt_r != {CW{1'b0}}) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      halted_r <= halted_r | (issue_s & id_hlt);
      hlt_wb_r <= hlt_wb_r | trk_hlt_r[FWD_STAGES-1];
      byp_oh_r <= byp_nxt_s;
    end
  end

endmodule
